// File: rtl/time_adjust_sequencer.sv
// time_adjust_sequencer
//   Owns the clock time and alarm registers of the alarm clock and sequences
//   every update to them. In run mode the time advances on sec_tick. In adjust
//   mode up/down pulses step the one field that EN selects. This block also
//   runs the alarm ringing state machine.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   sec_tick      : one-cycle pulse per second
//   adjust        : 1 = adjust mode
//   EN[4:0]       : one-hot field select (clock min, clock hr, alarm min,
//                   alarm hr, alarm enable)
//   up, down      : one-cycle increment/decrement pulses
//   center        : one-cycle silence pulse
//   sec, min, hr  : clock time
//   alm_min/alm_hr: alarm time
//   alarm_on      : alarm armed
//   ringing       : buzzer drive
module time_adjust_sequencer #(
    parameter int unsigned RING_SECONDS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       adjust,
    input  logic [4:0] EN,
    input  logic       up,
    input  logic       down,
    input  logic       center,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic [5:0] alm_min,
    output logic [4:0] alm_hr,
    output logic       alarm_on,
    output logic       ringing
);

    typedef enum logic {
        IDLE,
        RINGING
    } ring_state_t;

    ring_state_t state, state_nx;
    logic [7:0]  ring_cnt, ring_cnt_nx;
    logic        adj_q;

    logic        en_valid;
    logic        step_up, step_dn;
    logic        sec_wrap;
    logic        trigger;

    logic [5:0]  min_up, min_dn, amin_up, amin_dn;
    logic [4:0]  hr_up, hr_dn, ahr_up, ahr_dn;
    logic [4:0]  hr_carry;

    // Modular neighbours of every field, shared by run-mode carry and adjust.
    always_comb begin
        min_up  = (min == 6'd59)     ? '0 : min + 6'd1;
        min_dn  = (min == 6'd0)      ? 6'd59 : min - 6'd1;
        amin_up = (alm_min == 6'd59) ? '0 : alm_min + 6'd1;
        amin_dn = (alm_min == 6'd0)  ? 6'd59 : alm_min - 6'd1;
        hr_up   = (hr == 5'd23)      ? '0 : hr + 5'd1;
        hr_dn   = (hr == 5'd0)       ? 5'd23 : hr - 5'd1;
        ahr_up  = (alm_hr == 5'd23)  ? '0 : alm_hr + 5'd1;
        ahr_dn  = (alm_hr == 5'd0)   ? 5'd23 : alm_hr - 5'd1;
    end

    always_comb begin
        en_valid = (EN != '0) && ((EN & (EN - 5'd1)) == '0);
        step_up  = up & ~down;
        step_dn  = down & ~up;
        sec_wrap = ~adjust & sec_tick & (sec == 6'd59);
        hr_carry = (min == 6'd59) ? hr_up : hr;
        // Trigger compares the alarm against the time this tick is about to
        // produce, so the match lands exactly on hh:mm:00.
        trigger  = sec_wrap & alarm_on & (min_up == alm_min) & (hr_carry == alm_hr);
    end

    // Time and alarm registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec      <= '0;
            min      <= '0;
            hr       <= '0;
            alm_min  <= '0;
            alm_hr   <= '0;
            alarm_on <= 1'b0;
            adj_q    <= 1'b0;
        end else begin
            adj_q <= adjust;
            if (!adjust) begin
                if (sec_tick) begin
                    if (sec == 6'd59) begin
                        sec <= '0;
                        min <= min_up;
                        hr  <= hr_carry;
                    end else begin
                        sec <= sec + 6'd1;
                    end
                end
            end else begin
                if (!adj_q) begin
                    sec <= '0;
                end
                if (en_valid && (step_up || step_dn)) begin
                    unique case (1'b1)
                        EN[0]: min      <= step_up ? min_up  : min_dn;
                        EN[1]: hr       <= step_up ? hr_up   : hr_dn;
                        EN[2]: alm_min  <= step_up ? amin_up : amin_dn;
                        EN[3]: alm_hr   <= step_up ? ahr_up  : ahr_dn;
                        EN[4]: alarm_on <= ~alarm_on;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Ring FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ring_cnt <= '0;
        end else begin
            state    <= state_nx;
            ring_cnt <= ring_cnt_nx;
        end
    end

    // Ring FSM next state. Silence causes take priority over a tick arriving
    // in the same cycle.
    always_comb begin
        state_nx    = state;
        ring_cnt_nx = ring_cnt;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_nx    = RINGING;
                    ring_cnt_nx = '0;
                end
            end
            RINGING: begin
                if (center || !alarm_on || adjust) begin
                    state_nx = IDLE;
                end else if (sec_tick) begin
                    if (32'(ring_cnt) + 32'd1 >= RING_SECONDS) begin
                        state_nx = IDLE;
                    end else begin
                        ring_cnt_nx = ring_cnt + 8'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ringing = (state == RINGING);

endmodule
